// File: rtl/acc_pkg.sv
// ============================================================================
//  Module   : acc_pkg
//  Desc     : Shared state, opcode and datapath-select encodings for the
//             16-bit accumulator CPU.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package acc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEM_RD = 4'd2,
        S_MEM_WR = 4'd3,
        S_ALU_EX = 4'd4,
        S_ACC_WB = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_SP_DEC = 4'd8,
        S_SP_INC = 4'd9,
        S_HALT   = 4'd10
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP   = 4'd0,
        CLS_LOAD  = 4'd1,
        CLS_STORE = 4'd2,
        CLS_ALU   = 4'd3,
        CLS_ADDI  = 4'd4,
        CLS_BEQZ  = 4'd5,
        CLS_JUMP  = 4'd6,
        CLS_PUSH  = 4'd7,
        CLS_POP   = 4'd8,
        CLS_HALT  = 4'd9
    } opclass_e;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_ADDI  = 4'd6;
    localparam logic [3:0] OP_BEQZ  = 4'd7;
    localparam logic [3:0] OP_JUMP  = 4'd8;
    localparam logic [3:0] OP_PUSH  = 4'd9;
    localparam logic [3:0] OP_POP   = 4'd10;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [2:0] SRCA_PC  = 3'd0;
    localparam logic [2:0] SRCA_ACC = 3'd1;
    localparam logic [2:0] SRCA_SP  = 3'd2;

    localparam logic [3:0] SRCB_TWO = 4'd0;
    localparam logic [3:0] SRCB_SE  = 4'd1;
    localparam logic [3:0] SRCB_MDR = 4'd2;
    localparam logic [3:0] SRCB_ZE  = 4'd3;
    localparam logic [3:0] SRCB_SL1 = 4'd4;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_PASSA = 3'd5;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] IORD_PC = 2'd0;
    localparam logic [1:0] IORD_ZE = 2'd1;
    localparam logic [1:0] IORD_SP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/acc_opdecode.sv
// ============================================================================
//  Module   : acc_opdecode
//  Desc     : Combinational opcode to instruction-class and ALU-op mapping.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module acc_opdecode
    import acc_pkg::*;
(
    input  logic [3:0] opcode_i,
    output opclass_e   opclass_o,
    output logic [2:0] aluop_o
);

    always_comb begin
        opclass_o = CLS_NOP;
        aluop_o   = ALU_ADD;
        case (opcode_i)
            OP_LOAD:  opclass_o = CLS_LOAD;
            OP_STORE: opclass_o = CLS_STORE;
            OP_ADD:   opclass_o = CLS_ALU;
            OP_SUB: begin
                opclass_o = CLS_ALU;
                aluop_o   = ALU_SUB;
            end
            OP_AND: begin
                opclass_o = CLS_ALU;
                aluop_o   = ALU_AND;
            end
            OP_OR: begin
                opclass_o = CLS_ALU;
                aluop_o   = ALU_OR;
            end
            OP_ADDI:  opclass_o = CLS_ADDI;
            OP_BEQZ:  opclass_o = CLS_BEQZ;
            OP_JUMP:  opclass_o = CLS_JUMP;
            OP_PUSH:  opclass_o = CLS_PUSH;
            OP_POP:   opclass_o = CLS_POP;
            OP_HALT:  opclass_o = CLS_HALT;
            default:  opclass_o = CLS_NOP;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/acc_control.sv
// ============================================================================
//  Module   : acc_control
//  Desc     : Multicycle control FSM for the 16-bit accumulator CPU.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module acc_control
    import acc_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        Zero,
    input  logic        MemReady,
    output logic [2:0]  SrcA,
    output logic [3:0]  SrcB,
    output logic [2:0]  ALUOP,
    output logic [1:0]  PCSrc,
    output logic [1:0]  IorD,
    output logic        ACCSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MDRWrite,
    output logic        PCWrite,
    output logic        ACCWrite,
    output logic        SPWrite,
    output logic        Halted,
    output logic [3:0]  State
);

    state_e     state_q;
    state_e     state_d;
    opclass_e   w_cls;
    logic [2:0] w_aluop;
    logic       w_ir_unused;

    // Operand field of IR feeds the datapath directly, not the control.
    assign w_ir_unused = ^IR[11:0];

    acc_opdecode u_opdecode (
        .opcode_i  (IR[15:12]),
        .opclass_o (w_cls),
        .aluop_o   (w_aluop)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (w_cls)
                    CLS_LOAD, CLS_ALU, CLS_POP: state_d = S_MEM_RD;
                    CLS_STORE: state_d = S_MEM_WR;
                    CLS_ADDI:  state_d = S_ALU_EX;
                    CLS_BEQZ:  state_d = S_BRANCH;
                    CLS_JUMP:  state_d = S_JUMP;
                    CLS_PUSH:  state_d = S_SP_DEC;
                    CLS_HALT:  state_d = S_HALT;
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEM_RD: begin
                if (MemReady) begin
                    case (w_cls)
                        CLS_LOAD: state_d = S_ACC_WB;
                        CLS_ALU:  state_d = S_ALU_EX;
                        CLS_POP:  state_d = S_SP_INC;
                        default:  state_d = S_FETCH;
                    endcase
                end
            end
            S_MEM_WR: if (MemReady) state_d = S_FETCH;
            S_ALU_EX: state_d = S_ACC_WB;
            S_ACC_WB: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_SP_DEC: state_d = S_MEM_WR;
            S_SP_INC: state_d = S_ACC_WB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        SrcA     = SRCA_PC;
        SrcB     = SRCB_TWO;
        ALUOP    = ALU_ADD;
        PCSrc    = PCSRC_ALU;
        IorD     = IORD_PC;
        ACCSrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MDRWrite = 1'b0;
        PCWrite  = 1'b0;
        ACCWrite = 1'b0;
        SPWrite  = 1'b0;
        Halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: SrcB = SRCB_SL1;
            S_MEM_RD: begin
                MemRead  = 1'b1;
                IorD     = (w_cls == CLS_POP) ? IORD_SP : IORD_ZE;
                MDRWrite = MemReady;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = (w_cls == CLS_PUSH) ? IORD_SP : IORD_ZE;
            end
            S_ALU_EX: begin
                SrcA  = SRCA_ACC;
                SrcB  = (w_cls == CLS_ADDI) ? SRCB_SE : SRCB_MDR;
                ALUOP = w_aluop;
            end
            S_ACC_WB: begin
                ACCWrite = 1'b1;
                ACCSrc   = (w_cls == CLS_LOAD) || (w_cls == CLS_POP);
            end
            S_BRANCH: begin
                SrcA    = SRCA_ACC;
                ALUOP   = ALU_PASSA;
                PCSrc   = PCSRC_ALUOUT;
                PCWrite = Zero;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
            end
            S_SP_DEC: begin
                SrcA    = SRCA_SP;
                ALUOP   = ALU_SUB;
                SPWrite = 1'b1;
            end
            S_SP_INC: begin
                SrcA    = SRCA_SP;
                SPWrite = 1'b1;
            end
            S_HALT:   Halted = 1'b1;
            default: ;
        endcase
    end

    assign State = state_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_control.sv
// ============================================================================
//  Module   : tb_acc_control
//  Desc     : Cycle-by-cycle vector bench for the accumulator control FSM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_acc_control;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] IR = 16'h0000;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic [2:0]  SrcA;
    logic [3:0]  SrcB;
    logic [2:0]  ALUOP;
    logic [1:0]  PCSrc;
    logic [1:0]  IorD;
    logic        ACCSrc;
    logic        MemRead, MemWrite, IRWrite, MDRWrite, PCWrite, ACCWrite, SPWrite, Halted;
    logic [3:0]  State;

    int n_checks = 0;
    int n_errors = 0;

    acc_control dut (
        .CLK      (CLK),
        .reset    (reset),
        .IR       (IR),
        .Zero     (Zero),
        .MemReady (MemReady),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .ALUOP    (ALUOP),
        .PCSrc    (PCSrc),
        .IorD     (IorD),
        .ACCSrc   (ACCSrc),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .MDRWrite (MDRWrite),
        .PCWrite  (PCWrite),
        .ACCWrite (ACCWrite),
        .SPWrite  (SPWrite),
        .Halted   (Halted),
        .State    (State)
    );

    always #5 CLK = ~CLK;

    // Packed view: State,SrcA,SrcB,ALUOP,PCSrc,IorD,ACCSrc, then enables
    // MemRead,MemWrite,IRWrite,MDRWrite,PCWrite,ACCWrite,SPWrite,Halted.
    logic [26:0] w_act;
    assign w_act = {State, SrcA, SrcB, ALUOP, PCSrc, IorD, ACCSrc,
                    MemRead, MemWrite, IRWrite, MDRWrite, PCWrite, ACCWrite, SPWrite, Halted};

    typedef struct {
        logic [95:0] name;
        logic [15:0] ir;
        logic        z;
        logic        mr;
        logic [26:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [95:0] name, input logic [15:0] ir,
                                input logic z, input logic mr, input logic [3:0] st,
                                input logic [2:0] a, input logic [3:0] b, input logic [2:0] op,
                                input logic [1:0] pc, input logic [1:0] io, input logic acs,
                                input logic [7:0] en);
        vec_t v;
        v.name = name;
        v.ir   = ir;
        v.z    = z;
        v.mr   = mr;
        v.exp  = {st, a, b, op, pc, io, acs, en};
        vecs.push_back(v);
    endfunction

    task automatic check(input logic [95:0] name, input logic [26:0] act, input logic [26:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %0s: got state=%0d vec=%h, expected state=%0d vec=%h",
                     name, act[26:23], act, exp[26:23], exp);
        end
    endtask

    initial begin
        // ADD: full five-cycle path
        add("add_fetch",  16'h2010, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("add_decode", 16'h2010, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("add_memrd",  16'h2010, 0, 1, 4'd2, 3'd0, 4'd0, 3'd0, 2'd0, 2'd1, 0, 8'b1001_0000);
        add("add_aluex",  16'h2010, 0, 1, 4'd4, 3'd1, 4'd2, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("add_accwb",  16'h2010, 0, 1, 4'd5, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0100);
        // SUB with one wait state in MEM_RD
        add("sub_fetch",  16'h3000, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("sub_decode", 16'h3000, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("sub_rdwait", 16'h3000, 0, 0, 4'd2, 3'd0, 4'd0, 3'd0, 2'd0, 2'd1, 0, 8'b1000_0000);
        add("sub_memrd",  16'h3000, 0, 1, 4'd2, 3'd0, 4'd0, 3'd0, 2'd0, 2'd1, 0, 8'b1001_0000);
        add("sub_aluex",  16'h3000, 0, 1, 4'd4, 3'd1, 4'd2, 3'd1, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("sub_accwb",  16'h3000, 0, 1, 4'd5, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0100);
        // LOAD with three FETCH wait states; MemReady in DECODE is ignored
        for (int i = 0; i < 3; i++)
            add("ld_fwait",   16'h0000, 0, 0, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1000_0000);
        add("ld_fetch",   16'h0000, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("ld_decode",  16'h0000, 0, 0, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("ld_memrd",   16'h0000, 0, 1, 4'd2, 3'd0, 4'd0, 3'd0, 2'd0, 2'd1, 0, 8'b1001_0000);
        add("ld_accwb",   16'h0000, 0, 1, 4'd5, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 1, 8'b0000_0100);
        // BEQZ taken then not taken
        add("bz1_fetch",  16'h7004, 1, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("bz1_decode", 16'h7004, 1, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("bz1_branch", 16'h7004, 1, 1, 4'd6, 3'd1, 4'd0, 3'd5, 2'd1, 2'd0, 0, 8'b0000_1000);
        add("bz0_fetch",  16'h7004, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("bz0_decode", 16'h7004, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("bz0_branch", 16'h7004, 0, 1, 4'd6, 3'd1, 4'd0, 3'd5, 2'd1, 2'd0, 0, 8'b0000_0000);
        // PUSH then POP
        add("psh_fetch",  16'h9000, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("psh_decode", 16'h9000, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("psh_spdec",  16'h9000, 0, 1, 4'd8, 3'd2, 4'd0, 3'd1, 2'd0, 2'd0, 0, 8'b0000_0010);
        add("psh_memwr",  16'h9000, 0, 1, 4'd3, 3'd0, 4'd0, 3'd0, 2'd0, 2'd2, 0, 8'b0100_0000);
        add("pop_fetch",  16'hA000, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("pop_decode", 16'hA000, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("pop_memrd",  16'hA000, 0, 1, 4'd2, 3'd0, 4'd0, 3'd0, 2'd0, 2'd2, 0, 8'b1001_0000);
        add("pop_spinc",  16'hA000, 0, 1, 4'd9, 3'd2, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0010);
        add("pop_accwb",  16'hA000, 0, 1, 4'd5, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 1, 8'b0000_0100);
        // ADDI, AND, OR
        add("adi_fetch",  16'h6005, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("adi_decode", 16'h6005, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("adi_aluex",  16'h6005, 0, 1, 4'd4, 3'd1, 4'd1, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("adi_accwb",  16'h6005, 0, 1, 4'd5, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0100);
        add("and_fetch",  16'h4000, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("and_decode", 16'h4000, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("and_memrd",  16'h4000, 0, 1, 4'd2, 3'd0, 4'd0, 3'd0, 2'd0, 2'd1, 0, 8'b1001_0000);
        add("and_aluex",  16'h4000, 0, 1, 4'd4, 3'd1, 4'd2, 3'd2, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("and_accwb",  16'h4000, 0, 1, 4'd5, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0100);
        add("or_fetch",   16'h5000, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("or_decode",  16'h5000, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("or_memrd",   16'h5000, 0, 1, 4'd2, 3'd0, 4'd0, 3'd0, 2'd0, 2'd1, 0, 8'b1001_0000);
        add("or_aluex",   16'h5000, 0, 1, 4'd4, 3'd1, 4'd2, 3'd3, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("or_accwb",   16'h5000, 0, 1, 4'd5, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0100);
        // STORE with one MEM_WR wait state
        add("st_fetch",   16'h1000, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("st_decode",  16'h1000, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("st_wrwait",  16'h1000, 0, 0, 4'd3, 3'd0, 4'd0, 3'd0, 2'd0, 2'd1, 0, 8'b0100_0000);
        add("st_memwr",   16'h1000, 0, 1, 4'd3, 3'd0, 4'd0, 3'd0, 2'd0, 2'd1, 0, 8'b0100_0000);
        // JUMP, NOP, HALT
        add("jmp_fetch",  16'h8123, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("jmp_decode", 16'h8123, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("jmp_jump",   16'h8123, 0, 1, 4'd7, 3'd0, 4'd0, 3'd0, 2'd2, 2'd0, 0, 8'b0000_1000);
        add("nop_fetch",  16'hC000, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("nop_decode", 16'hC000, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        add("hlt_fetch",  16'hF000, 0, 1, 4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b1010_1000);
        add("hlt_decode", 16'hF000, 0, 1, 4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0000);
        for (int i = 0; i < 10; i++)
            add("hlt_hold",   16'hF000, 1, 1, 4'd10, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 0, 8'b0000_0001);

        // Reset state, with MemReady low then high
        reset = 1'b0;
        MemReady = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_mr0", w_act, {4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0, 8'b1000_0000});
        MemReady = 1'b1;
        #1;
        check("rst_mr1", w_act, {4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0, 8'b1010_1000});
        @(posedge CLK);
        #1;
        check("rst_hold", w_act, {4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0, 8'b1010_1000});
        reset = 1'b1;

        foreach (vecs[i]) begin
            IR       = vecs[i].ir;
            Zero     = vecs[i].z;
            MemReady = vecs[i].mr;
            @(negedge CLK);
            check(vecs[i].name, w_act, vecs[i].exp);
            @(posedge CLK);
            #1;
        end

        // Reset is the only way out of HALT
        reset = 1'b0;
        MemReady = 1'b0;
        #1;
        check("hlt_reset", w_act, {4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0, 8'b1000_0000});
        @(posedge CLK);
        #1;
        reset = 1'b1;

        // Reset asserted mid-MEM_RD of a LOAD abandons it
        IR = 16'h0000;
        MemReady = 1'b1;
        @(negedge CLK);
        check("mr_fetch", w_act, {4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0, 8'b1010_1000});
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        MemReady = 1'b0;
        @(negedge CLK);
        check("mr_memrd", w_act, {4'd2, 3'd0, 4'd0, 3'd0, 2'd0, 2'd1, 1'b0, 8'b1000_0000});
        #2;
        reset = 1'b0;
        #1;
        check("mr_async", w_act, {4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0, 8'b1000_0000});
        MemReady = 1'b1;
        @(posedge CLK);
        #1;
        check("mr_inrst", w_act, {4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0, 8'b1010_1000});
        reset = 1'b1;
        @(negedge CLK);
        check("mr_release", w_act, {4'd0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0, 8'b1010_1000});
        @(posedge CLK);
        #1;
        check("mr_decode", w_act, {4'd1, 3'd0, 4'd4, 3'd0, 2'd0, 2'd0, 1'b0, 8'b0000_0000});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
